// File: rtl/addsub_chunked_n.sv
// addsub_chunked_n -- multi-cycle add/subtract, CHUNK bits per clock.
//
// A WIDTH-bit add or subtract is split into N = WIDTH/CHUNK slices. One slice
// is computed per clock, and the carry is held in a register between slices,
// so the combinational carry chain is only CHUNK bits deep.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_start  request; accepted only in IDLE or DONE
//   i_a      operand A (WIDTH)
//   i_b      operand B (WIDTH)
//   i_mgate  0 = add (a+b+cin), 1 = subtract (a-b-cin)
//   i_cin    carry-in for add, borrow-in for subtract
//   o_sum    registered result (WIDTH); changes only at commit
//   o_cout   final raw carry (for subtract, 1 = no borrow)
//   o_ovf    signed overflow of the last result
//   o_busy   high while an operation is running
//   o_done   one-cycle pulse when o_sum/o_cout/o_ovf are updated
//
// Build option
//   ADDSUB_SAT_EN  When defined, o_sum saturates to the signed limit on
//                  overflow. o_cout and o_ovf still report the raw values.
module addsub_chunked_n #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mgate,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_busy,
   output logic             o_done
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;       // shifts right one slice per RUN cycle
   logic [WIDTH-1:0] r_b;       // already inverted for subtract
   logic             r_a_msb;   // sign bits kept for the overflow test
   logic             r_b_msb;
   logic             r_c;
   logic [WIDTH-1:0] r_s;       // shadow result, fills from the top down
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [CHUNK:0]   w_slice;
   logic [WIDTH-1:0] w_s_next;
   logic             w_ovf;
   logic [WIDTH-1:0] w_sum_commit;
   logic             w_accept;

   // The low slice of the shifting operands is always the one being worked on.
   assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, r_c};

   // Each new slice enters at the top and earlier slices move down, so after
   // N cycles slice 0 sits in the low bits.
   generate
      if (N == 1) begin : g_single
         assign w_s_next = w_slice[CHUNK-1:0];
      end else begin : g_multi
         assign w_s_next = {w_slice[CHUNK-1:0], r_s[WIDTH-1:CHUNK]};
      end
   endgenerate

   assign w_ovf = (r_a_msb == r_b_msb) && (w_s_next[WIDTH-1] != r_a_msb);

`ifdef ADDSUB_SAT_EN
   // On overflow the sign of A gives the direction: a positive A clips high.
   assign w_sum_commit = !w_ovf ? w_s_next :
                         r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_sum_commit = w_s_next;
`endif

   assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_c     <= 1'b0;
         r_s     <= '0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_a   <= r_a >> CHUNK;
               r_b   <= r_b >> CHUNK;
               r_c   <= w_slice[CHUNK];
               r_s   <= w_s_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_sum   <= w_sum_commit;
                  r_cout  <= w_slice[CHUNK];
                  r_ovf   <= w_ovf;
                  r_state <= S_DONE;
               end
            end
            default: begin
               if (w_accept) begin
                  // Subtract is done as a + ~b + ~borrow.
                  r_a     <= i_a;
                  r_b     <= i_b ^ {WIDTH{i_mgate}};
                  r_a_msb <= i_a[WIDTH-1];
                  r_b_msb <= i_b[WIDTH-1] ^ i_mgate;
                  r_c     <= i_mgate ? ~i_cin : i_cin;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;
   assign o_busy = (r_state == S_RUN);
   // DONE always lasts exactly one cycle, so the pulse is the state itself.
   assign o_done = (r_state == S_DONE);

endmodule
